// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous video RAM between scan-out (fixed priority) and the draw engine.
// Latency: grant is combinational, mem_* is registered (+1 cycle), read data returns RD_LAT+1 cycles after grant.
// Backpressure: req=1 with gnt=0 is a stall and the requester holds its request; macro VRAM_ARB_STARVE_GUARD_EN enables the draw starve guard.
module vram_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 8,
  parameter int RD_LAT       = 2,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_gnt,
  output logic              scan_rvalid,
  output logic [DATA_W-1:0] scan_rdata,
  input  logic              draw_req,
  input  logic              draw_we,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_wdata,
  output logic              draw_gnt,
  output logic              draw_rvalid,
  output logic [DATA_W-1:0] draw_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic force_draw;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  logic [7:0] starve_cnt;

  // The guard fires on the cycle the lost-cycle count has reached the limit.
  assign force_draw = draw_req && (starve_cnt == 8'(STARVE_LIMIT));

  // Count consecutive lost draw cycles; saturate, clear on a draw grant or an idle draw port.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 8'd0;
    end else if (!draw_req || draw_gnt) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != 8'hFF) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  // Strict fixed priority: scan can starve draw indefinitely.
  assign force_draw = 1'b0 && (STARVE_LIMIT > 0);
`endif

  // Scan wins unless the guard forces draw; both grants are held low during reset.
  assign scan_gnt = !reset && scan_req && !force_draw;
  assign draw_gnt = !reset && draw_req && !scan_gnt;

  // A tag enters the return pipeline for every granted read; writes leave a bubble.
  logic new_tag_v;
  logic new_tag_p;
  assign new_tag_v = scan_gnt || (draw_gnt && !draw_we);
  assign new_tag_p = draw_gnt;

  // Register the winner onto the memory port; idle cycles drop en/we and hold address/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (scan_gnt) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= scan_addr;
    end else if (draw_gnt) begin
      mem_en    <= 1'b1;
      mem_we    <= draw_we;
      mem_addr  <= draw_addr;
      mem_wdata <= draw_wdata;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // tag_v/tag_p[0] lines up with mem_en; the extra output stage lines up with mem_rdata.
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_p;
  logic              ret_v;
  logic              ret_p;

  // Shift {valid, port} tags in issue order; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v <= '0;
      tag_p <= '0;
      ret_v <= 1'b0;
      ret_p <= 1'b0;
    end else begin
      tag_v[0] <= new_tag_v;
      tag_p[0] <= new_tag_p;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_p[i] <= tag_p[i-1];
      end
      ret_v <= tag_v[RD_LAT-1];
      ret_p <= tag_p[RD_LAT-1];
    end
  end

  // Route the returning word to the port that issued it; data lines are shared.
  assign scan_rvalid = ret_v && !ret_p;
  assign draw_rvalid = ret_v && ret_p;
  assign scan_rdata  = mem_rdata;
  assign draw_rdata  = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed bench for vram_arbiter with a behavioural RD_LAT-cycle memory.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Expected values are hand-computed constants; unwritten memory words read as addr[7:0]^8'hB5.
module tb_vram_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_gnt, scan_rvalid;
  logic [DATA_W-1:0] scan_rdata;
  logic              draw_req, draw_we;
  logic [ADDR_W-1:0] draw_addr;
  logic [DATA_W-1:0] draw_wdata;
  logic              draw_gnt, draw_rvalid;
  logic [DATA_W-1:0] draw_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int fails  = 0;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_LIMIT(15)) dut (
    .clk(clk), .reset(reset),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
    .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
    .draw_req(draw_req), .draw_we(draw_we), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
    .draw_gnt(draw_gnt), .draw_rvalid(draw_rvalid), .draw_rdata(draw_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: writes land on the edge, reads appear RD_LAT cycles after mem_en.
  bit          wr_flag [0:(1<<ADDR_W)-1];
  logic [7:0]  wr_data [0:(1<<ADDR_W)-1];
  logic [7:0]  rpipe   [RD_LAT];

  function automatic logic [7:0] fill(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'hB5;
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wr_flag[mem_addr] <= 1'b1;
      wr_data[mem_addr] <= mem_wdata;
    end
    rpipe[0] <= (mem_en && !mem_we) ? (wr_flag[mem_addr] ? wr_data[mem_addr] : fill(mem_addr)) : 8'h00;
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RD_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    scan_req = 1'b0; draw_req = 1'b0; draw_we = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    reset = 1'b1; scan_req = 1'b1; draw_req = 1'b1; draw_we = 1'b0;
    scan_addr = '0; draw_addr = '0; draw_wdata = '0;
    @(negedge clk);
    checks++; if ({scan_gnt, draw_gnt} !== 2'b00) begin fails++; $display("FAIL reset_gnt got=%b want=00", {scan_gnt, draw_gnt}); end
    tick();
    @(negedge clk);
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata, scan_rvalid, draw_rvalid} !== '0) begin
      fails++; $display("FAIL reset_outputs en=%b we=%b addr=%h wd=%h srv=%b drv=%b want all 0",
                        mem_en, mem_we, mem_addr, mem_wdata, scan_rvalid, draw_rvalid); end
    reset = 1'b0; idle();
    tick();
    // three scan reads, then a one-cycle reset while they are in flight
    for (int k = 0; k < 3; k++) begin
      scan_req = 1'b1; scan_addr = 17'h40 + 17'(k);
      tick();
    end
    idle(); reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin fails++; $display("FAIL reset_midop_mem_en got=%b want=0", mem_en); end
`ifdef VRAM_ARB_STARVE_GUARD_EN
    checks++; if (dut.starve_cnt !== 8'd0) begin fails++; $display("FAIL reset_starve_cnt got=%0d want=0", dut.starve_cnt); end
`endif
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (scan_rvalid || draw_rvalid) pulses++;
      tick();
    end
    checks++; if (pulses !== 0) begin fails++; $display("FAIL reset_midop_rvalid pulses=%0d want=0", pulses); end
  endtask

  task automatic test_lone_scan();
    scan_req = 1'b1; scan_addr = 17'h00010;
    @(negedge clk);
    checks++; if ({scan_gnt, draw_gnt} !== 2'b10) begin fails++; $display("FAIL lone_gnt got=%b want=10", {scan_gnt, draw_gnt}); end
    tick(); idle();
    @(negedge clk);
    checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 17'h00010}) begin
      fails++; $display("FAIL lone_issue en=%b we=%b addr=%h want 1 0 00010", mem_en, mem_we, mem_addr); end
    tick();
    @(negedge clk);
    checks++; if ({mem_en, scan_rvalid} !== 2'b00) begin fails++; $display("FAIL lone_c2 en=%b srv=%b want 0 0", mem_en, scan_rvalid); end
    tick();
    @(negedge clk);
    checks++; if ({scan_rvalid, draw_rvalid, scan_rdata} !== {1'b1, 1'b0, 8'hA5}) begin
      fails++; $display("FAIL lone_return srv=%b drv=%b data=%h want 1 0 a5", scan_rvalid, draw_rvalid, scan_rdata); end
    tick();
  endtask

  task automatic test_write_read();
    draw_req = 1'b1; draw_we = 1'b1; draw_addr = 17'h1F000; draw_wdata = 8'h3C;
    @(negedge clk);
    checks++; if ({scan_gnt, draw_gnt} !== 2'b01) begin fails++; $display("FAIL wr_gnt got=%b want=01", {scan_gnt, draw_gnt}); end
    tick(); draw_we = 1'b0;
    @(negedge clk);
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 17'h1F000, 8'h3C}) begin
      fails++; $display("FAIL wr_issue en=%b we=%b addr=%h wd=%h want 1 1 1f000 3c", mem_en, mem_we, mem_addr, mem_wdata); end
    checks++; if (draw_gnt !== 1'b1) begin fails++; $display("FAIL rd_gnt got=%b want=1", draw_gnt); end
    tick(); idle();
    @(negedge clk);
    checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 17'h1F000}) begin
      fails++; $display("FAIL rd_issue en=%b we=%b addr=%h want 1 0 1f000", mem_en, mem_we, mem_addr); end
    tick();
    @(negedge clk);
    checks++; if ({scan_rvalid, draw_rvalid} !== 2'b00) begin fails++; $display("FAIL rd_early got=%b want=00", {scan_rvalid, draw_rvalid}); end
    tick();
    @(negedge clk);
    checks++; if ({scan_rvalid, draw_rvalid, draw_rdata} !== {1'b0, 1'b1, 8'h3C}) begin
      fails++; $display("FAIL rd_return srv=%b drv=%b data=%h want 0 1 3c", scan_rvalid, draw_rvalid, draw_rdata); end
    tick();
  endtask

  task automatic test_both_requesting();
    // per cycle: {scan_gnt, draw_gnt}, {scan_rvalid, draw_rvalid}, expected return data
    logic [1:0] exp_g [9]  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] exp_r [9]  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    logic [7:0] exp_d [9]  = '{8'h00, 8'h00, 8'h00, 8'hB5, 8'hB4, 8'hB7, 8'hB6, 8'h76, 8'h00};
    for (int c = 0; c < 9; c++) begin
      scan_req = (c < 4); scan_addr = 17'h100 + 17'(c);
      draw_req = (c < 5); draw_we = 1'b0; draw_addr = 17'h2C3;
      @(negedge clk);
      checks++; if ({scan_gnt, draw_gnt} !== exp_g[c]) begin
        fails++; $display("FAIL both_gnt c%0d got=%b want=%b", c, {scan_gnt, draw_gnt}, exp_g[c]); end
      checks++; if ({scan_rvalid, draw_rvalid} !== exp_r[c]) begin
        fails++; $display("FAIL both_rvalid c%0d got=%b want=%b", c, {scan_rvalid, draw_rvalid}, exp_r[c]); end
      if (exp_r[c] != 2'b00) begin
        checks++; if ((exp_r[c][1] ? scan_rdata : draw_rdata) !== exp_d[c]) begin
          fails++; $display("FAIL both_rdata c%0d got=%h want=%h", c, exp_r[c][1] ? scan_rdata : draw_rdata, exp_d[c]); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_starve();
    logic [1:0] want;
    int dg;
    dg = 0;
    scan_req = 1'b1; scan_addr = 17'h0; draw_req = 1'b1; draw_we = 1'b0; draw_addr = 17'h5;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
`ifdef VRAM_ARB_STARVE_GUARD_EN
      want = (c == 15 || c == 31) ? 2'b01 : 2'b10;
`else
      want = 2'b10;
`endif
      if (draw_gnt) dg++;
      checks++; if ({scan_gnt, draw_gnt} !== want) begin
        fails++; $display("FAIL starve_gnt c%0d got=%b want=%b", c, {scan_gnt, draw_gnt}, want); end
      tick();
    end
`ifdef VRAM_ARB_STARVE_GUARD_EN
    checks++; if (dg !== 2) begin fails++; $display("FAIL starve_count got=%0d want=2", dg); end
`else
    checks++; if (dg !== 0) begin fails++; $display("FAIL starve_count got=%0d want=0", dg); end
`endif
    idle();
    for (int c = 0; c < RD_LAT + 3; c++) tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] expq [$];
    int en_cnt, g_cnt, r_cnt;
    en_cnt = 0; g_cnt = 0; r_cnt = 0;
    for (int c = 0; c < 805; c++) begin
      if (c < 800 && c % 2 == 0) begin
        scan_req = 1'b1; scan_addr = 17'(c / 2); draw_req = 1'b0;
      end else if (c < 800) begin
        scan_req = 1'b0; draw_req = 1'b1; draw_we = 1'b1;
        draw_addr = 17'h10000 + 17'(c); draw_wdata = 8'(c);
      end else begin
        idle();
      end
      @(negedge clk);
      if (mem_en) en_cnt++;
      if (scan_gnt) begin g_cnt++; expq.push_back(fill(scan_addr)); end
      if (scan_rvalid) begin
        r_cnt++;
        checks++;
        if (expq.size() == 0) begin
          fails++; $display("FAIL b2b_rdata c%0d unexpected return data=%h", c, scan_rdata);
        end else if (scan_rdata !== expq[0]) begin
          fails++; $display("FAIL b2b_rdata c%0d got=%h want=%h", c, scan_rdata, expq[0]);
          void'(expq.pop_front());
        end else begin
          void'(expq.pop_front());
        end
      end
      tick();
    end
    idle();
    checks++; if (en_cnt !== 800) begin fails++; $display("FAIL b2b_mem_en count=%0d want=800", en_cnt); end
    checks++; if (g_cnt !== 400) begin fails++; $display("FAIL b2b_scan_gnt count=%0d want=400", g_cnt); end
    checks++; if (r_cnt !== 400) begin fails++; $display("FAIL b2b_scan_rvalid count=%0d want=400", r_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    scan_addr = '0; draw_addr = '0; draw_wdata = '0;
    tick();
    test_reset();
    test_lone_scan();
    test_write_read();
    test_both_requesting();
    test_starve();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
